// File: rtl/uc_pkg.sv
// Shared encodings for the interrupt-capable control unit: opcode class
// prefixes, branch/system function codes and the run/halt state type.
package uc_pkg;

  // Class prefixes for the two fully decoded top nibbles
  localparam logic [3:0] TOP_CMP = 4'b0001;
  localparam logic [3:0] TOP_SYS = 4'b0000;

  // Branch-class function codes (opcode[2:0] under prefix 001?)
  localparam logic [2:0] FN_J    = 3'd0;
  localparam logic [2:0] FN_JZ   = 3'd1;
  localparam logic [2:0] FN_JNZ  = 3'd2;
  localparam logic [2:0] FN_JA   = 3'd3;
  localparam logic [2:0] FN_JAE  = 3'd4;
  localparam logic [2:0] FN_JB   = 3'd5;
  localparam logic [2:0] FN_CALL = 3'd6;
  localparam logic [2:0] FN_RET  = 3'd7;

  // System-class function codes (opcode[2:0] under prefix 0000)
  localparam logic [2:0] FN_EI   = 3'd1;
  localparam logic [2:0] FN_DI   = 3'd2;
  localparam logic [2:0] FN_RETI = 3'd3;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

endpackage

// File: rtl/uc_decode.sv
// Purely combinational opcode decode. Produces the raw datapath controls
// plus class strobes; the top level applies interrupt suppression, stack
// over/underflow overrides and halt gating on top of these.
module uc_decode
  import uc_pkg::*;
#(
  parameter int OPW = 16
) (
  input  logic [OPW-1:0] opcode,
  input  logic           z_flag,
  input  logic           c_flag,
  output logic           s_inc,
  output logic           s_inm,
  output logic           we3,
  output logic           push,
  output logic           pop,
  output logic [2:0]     op_alu,
  output logic           is_flagw,
  output logic           is_call,
  output logic           is_ret,
  output logic           is_reti,
  output logic           is_ei,
  output logic           is_di
);

  logic [3:0] top;
  logic [2:0] fn;
  logic       unused_mid;

  assign top        = opcode[OPW-1 -: 4];
  assign fn         = opcode[2:0];
  // Middle opcode bits carry register/immediate fields for the datapath
  assign unused_mid = ^opcode[OPW-5:3];

  // Class decode; branch conditions use the flags as they stand before this edge
  always_comb begin
    s_inc    = 1'b1;
    s_inm    = 1'b0;
    we3      = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    op_alu   = 3'd0;
    is_flagw = 1'b0;
    is_call  = 1'b0;
    is_ret   = 1'b0;
    is_reti  = 1'b0;
    is_ei    = 1'b0;
    is_di    = 1'b0;
    if (top[3]) begin
      we3      = 1'b1;
      s_inm    = 1'b1;
      op_alu   = opcode[OPW-2 -: 3];
      is_flagw = 1'b1;
    end else if (top[2]) begin
      we3      = 1'b1;
      op_alu   = fn;
      is_flagw = 1'b1;
    end else if (top[1]) begin
      case (fn)
        FN_J:    s_inc = 1'b0;
        FN_JZ:   s_inc = !z_flag;
        FN_JNZ:  s_inc = z_flag;
        FN_JA:   s_inc = z_flag | c_flag;
        FN_JAE:  s_inc = c_flag;
        FN_JB:   s_inc = !c_flag;
        FN_CALL: begin
          push    = 1'b1;
          s_inc   = 1'b0;
          is_call = 1'b1;
        end
        default: begin
          pop    = 1'b1;
          s_inc  = 1'b0;
          is_ret = 1'b1;
        end
      endcase
    end else if (top == TOP_CMP) begin
      op_alu   = fn;
      is_flagw = 1'b1;
    end else begin
      case (fn)
        FN_EI:   is_ei = 1'b1;
        FN_DI:   is_di = 1'b1;
        FN_RETI: begin
          pop     = 1'b1;
          s_inc   = 1'b0;
          is_reti = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uc_irq_stack.sv
// Control unit with registered Z/C flags, return-stack occupancy tracking
// with over/underflow protection, a single-level maskable interrupt that
// shadows the flags, and an optional halt on stack fault.
module uc_irq_stack
  import uc_pkg::*;
#(
  parameter int  OPW           = 16,
  parameter int  STACK_DEPTH   = 8,
  parameter bit  HALT_ON_FAULT = 1'b1,
  localparam int SPW           = $clog2(STACK_DEPTH + 1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  input  logic           z_alu,
  input  logic           c_alu,
  input  logic           irq,
  output logic           s_inc,
  output logic           s_inm,
  output logic           s_irq,
  output logic           we3,
  output logic           push,
  output logic           pop,
  output logic [2:0]     op_alu,
  output logic           z_flag,
  output logic           c_flag,
  output logic           ie,
  output logic [SPW-1:0] sp_count,
  output logic           fault,
  output logic           halted
);

  localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

  state_t         state_q, state_d;
  logic           z_q, c_q, ie_q, fault_q, irq_pend_q;
  logic           z_d, c_d, ie_d, fault_d;
  logic [1:0]     shadow_q, shadow_d;
  logic [SPW-1:0] sp_q, sp_d;

  logic           d_s_inc, d_s_inm, d_we3, d_push, d_pop;
  logic [2:0]     d_op_alu;
  logic           d_is_flagw, d_is_call, d_is_ret, d_is_reti, d_is_ei, d_is_di;

  logic           sp_full, sp_empty, entry, exec, flag_wr, fault_set;

  uc_decode #(.OPW(OPW)) u_decode (
    .opcode   (opcode),
    .z_flag   (z_q),
    .c_flag   (c_q),
    .s_inc    (d_s_inc),
    .s_inm    (d_s_inm),
    .we3      (d_we3),
    .push     (d_push),
    .pop      (d_pop),
    .op_alu   (d_op_alu),
    .is_flagw (d_is_flagw),
    .is_call  (d_is_call),
    .is_ret   (d_is_ret),
    .is_reti  (d_is_reti),
    .is_ei    (d_is_ei),
    .is_di    (d_is_di)
  );

  assign sp_full  = (sp_q == SP_FULL);
  assign sp_empty = (sp_q == '0);
  // An interrupt needs a free stack slot for the return PC; otherwise it waits
  assign entry    = (state_q == RUN) && irq_pend_q && ie_q && !sp_full;
  // The fetched opcode only takes effect when running and not displaced by entry
  assign exec     = !reset && (state_q == RUN) && !entry;

  // Output controls: reset, then halt freeze, then interrupt entry, then decode
  always_comb begin
    s_inc     = 1'b1;
    s_inm     = 1'b0;
    s_irq     = 1'b0;
    we3       = 1'b0;
    push      = 1'b0;
    pop       = 1'b0;
    op_alu    = 3'd0;
    flag_wr   = 1'b0;
    fault_set = 1'b0;
    if (reset) begin
      s_inc = 1'b1;
    end else if (state_q == HALT) begin
      s_inc = 1'b0;
    end else if (entry) begin
      s_irq = 1'b1;
      push  = 1'b1;
      s_inc = 1'b0;
    end else begin
      s_inc   = d_s_inc;
      s_inm   = d_s_inm;
      we3     = d_we3;
      push    = d_push;
      pop     = d_pop;
      op_alu  = d_op_alu;
      flag_wr = d_is_flagw;
      // Stack overruns degrade to a NOP and raise the sticky fault
      if (d_is_call && sp_full) begin
        push      = 1'b0;
        s_inc     = 1'b1;
        fault_set = 1'b1;
      end
      if ((d_is_ret || d_is_reti) && sp_empty) begin
        pop       = 1'b0;
        s_inc     = 1'b1;
        fault_set = 1'b1;
      end
    end
  end

  // Next values for flags, shadow, interrupt enable, occupancy, fault and FSM
  always_comb begin
    z_d      = z_q;
    c_d      = c_q;
    ie_d     = ie_q;
    shadow_d = shadow_q;
    sp_d     = sp_q;
    fault_d  = fault_q | fault_set;
    state_d  = state_q;
    if (flag_wr) begin
      z_d = z_alu;
      c_d = c_alu;
    end
    if (exec && d_is_ei) ie_d = 1'b1;
    if (exec && d_is_di) ie_d = 1'b0;
    // An underflowing RETI leaves flags and ie untouched
    if (exec && d_is_reti && !sp_empty) begin
      {z_d, c_d} = shadow_q;
      ie_d       = 1'b1;
    end
    if (entry) begin
      ie_d     = 1'b0;
      shadow_d = {z_q, c_q};
    end
    if (push) sp_d = sp_q + SPW'(1);
    else if (pop) sp_d = sp_q - SPW'(1);
    if ((state_q == RUN) && HALT_ON_FAULT && fault_d) state_d = HALT;
  end

  // State registers; synchronous reset wins over every update
  always_ff @(posedge clk) begin
    if (reset) begin
      z_q        <= 1'b0;
      c_q        <= 1'b0;
      ie_q       <= 1'b0;
      shadow_q   <= 2'b00;
      sp_q       <= '0;
      fault_q    <= 1'b0;
      irq_pend_q <= 1'b0;
      state_q    <= RUN;
    end else begin
      z_q        <= z_d;
      c_q        <= c_d;
      ie_q       <= ie_d;
      shadow_q   <= shadow_d;
      sp_q       <= sp_d;
      fault_q    <= fault_d;
      irq_pend_q <= irq;
      state_q    <= state_d;
    end
  end

  assign z_flag   = z_q;
  assign c_flag   = c_q;
  assign ie       = ie_q;
  assign sp_count = sp_q;
  assign fault    = fault_q;
  assign halted   = (state_q == HALT);

endmodule

// File: tb/tb_uc_irq_stack.sv
// Bench for uc_irq_stack: two instances (halt-on-fault and flag-only) share
// one stimulus stream; a behavioural model predicts controls and state.
module tb_uc_irq_stack;

  localparam int OPW   = 16;
  localparam int DEPTH = 8;
  localparam int SPW   = $clog2(DEPTH + 1);

  // Opcode kinds used by the reference model
  localparam int K_ALUI = 0, K_ALUR = 1, K_BR = 2, K_CALL = 3, K_RET = 4;
  localparam int K_CMP = 5, K_EI = 6, K_DI = 7, K_RETI = 8, K_NOP = 9;

  // ---------------- clock / reset ----------------
  logic           clk    = 1'b0;
  logic           reset  = 1'b1;
  logic [OPW-1:0] opcode = '0;
  logic           z_alu  = 1'b0;
  logic           c_alu  = 1'b0;
  logic           irq    = 1'b0;

  always #5 clk = ~clk;

  logic           s_inc [2], s_inm [2], s_irq [2], we3 [2], push [2], pop [2];
  logic [2:0]     op_alu [2];
  logic           z_flag [2], c_flag [2], ie [2], fault [2], halted [2];
  logic [SPW-1:0] sp_count [2];

  uc_irq_stack #(.OPW(OPW), .STACK_DEPTH(DEPTH), .HALT_ON_FAULT(1'b1)) u_dut_halt (
    .clk(clk), .reset(reset), .opcode(opcode), .z_alu(z_alu), .c_alu(c_alu), .irq(irq),
    .s_inc(s_inc[0]), .s_inm(s_inm[0]), .s_irq(s_irq[0]), .we3(we3[0]),
    .push(push[0]), .pop(pop[0]), .op_alu(op_alu[0]), .z_flag(z_flag[0]),
    .c_flag(c_flag[0]), .ie(ie[0]), .sp_count(sp_count[0]), .fault(fault[0]),
    .halted(halted[0])
  );

  uc_irq_stack #(.OPW(OPW), .STACK_DEPTH(DEPTH), .HALT_ON_FAULT(1'b0)) u_dut_flag (
    .clk(clk), .reset(reset), .opcode(opcode), .z_alu(z_alu), .c_alu(c_alu), .irq(irq),
    .s_inc(s_inc[1]), .s_inm(s_inm[1]), .s_irq(s_irq[1]), .we3(we3[1]),
    .push(push[1]), .pop(pop[1]), .op_alu(op_alu[1]), .z_flag(z_flag[1]),
    .c_flag(c_flag[1]), .ie(ie[1]), .sp_count(sp_count[1]), .fault(fault[1]),
    .halted(halted[1])
  );

  // ---------------- scoreboard ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] exp_q[$];
  bit         state_known = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_z [2], m_c [2], m_ie [2], m_fault [2], m_halt [2], m_pend [2], m_shz [2], m_shc [2];
  int m_sp [2];

  function automatic int kind_of(input logic [OPW-1:0] op);
    int top, fn;
    top = int'(op) >> (OPW - 4);
    fn  = int'(op) % 8;
    if (top >= 8) return K_ALUI;
    if (top >= 4) return K_ALUR;
    if (top >= 2) return (fn == 6) ? K_CALL : (fn == 7) ? K_RET : K_BR;
    if (top == 1) return K_CMP;
    if (fn == 1) return K_EI;
    if (fn == 2) return K_DI;
    if (fn == 3) return K_RETI;
    return K_NOP;
  endfunction

  // Expected {s_inc,s_inm,s_irq,we3,push,pop,op_alu}
  function automatic logic [8:0] model_ctl(input int i, input logic [OPW-1:0] op, input bit rst);
    bit inc, inm, sirq, w, pu, po, taken;
    int alu, k, fn;
    inc = 1; inm = 0; sirq = 0; w = 0; pu = 0; po = 0; alu = 0; taken = 0;
    k  = kind_of(op);
    fn = int'(op) % 8;
    if (rst) begin
      inc = 1;
    end else if (m_halt[i]) begin
      inc = 0;
    end else if (m_pend[i] && m_ie[i] && m_sp[i] < DEPTH) begin
      sirq = 1; pu = 1; inc = 0;
    end else begin
      case (k)
        K_ALUI: begin w = 1; inm = 1; alu = (int'(op) >> (OPW - 4)) % 8; end
        K_ALUR: begin w = 1; alu = fn; end
        K_CMP:  alu = fn;
        K_BR: begin
          case (fn)
            0: taken = 1;
            1: taken = m_z[i];
            2: taken = !m_z[i];
            3: taken = !m_z[i] && !m_c[i];
            4: taken = !m_c[i];
            default: taken = m_c[i];
          endcase
          inc = !taken;
        end
        K_CALL: if (m_sp[i] < DEPTH) begin pu = 1; inc = 0; end
        K_RET, K_RETI: if (m_sp[i] > 0) begin po = 1; inc = 0; end
        default: ;
      endcase
    end
    return {inc, inm, sirq, w, pu, po, 3'(alu)};
  endfunction

  task automatic model_step(input int i, input logic [OPW-1:0] op, input bit za, input bit ca,
                            input bit irq_v, input bit rst);
    bit take, flt;
    int k;
    if (rst) begin
      m_z[i] = 0; m_c[i] = 0; m_ie[i] = 0; m_sp[i] = 0; m_fault[i] = 0;
      m_halt[i] = 0; m_pend[i] = 0; m_shz[i] = 0; m_shc[i] = 0;
      return;
    end
    take      = !m_halt[i] && m_pend[i] && m_ie[i] && m_sp[i] < DEPTH;
    m_pend[i] = irq_v;
    if (m_halt[i]) return;
    if (take) begin
      m_shz[i] = m_z[i]; m_shc[i] = m_c[i]; m_ie[i] = 0; m_sp[i]++;
      return;
    end
    flt = 0;
    k   = kind_of(op);
    case (k)
      K_ALUI, K_ALUR, K_CMP: begin m_z[i] = za; m_c[i] = ca; end
      K_CALL: if (m_sp[i] == DEPTH) flt = 1; else m_sp[i]++;
      K_RET:  if (m_sp[i] == 0) flt = 1; else m_sp[i]--;
      K_RETI: if (m_sp[i] == 0) flt = 1;
              else begin m_sp[i]--; m_z[i] = m_shz[i]; m_c[i] = m_shc[i]; m_ie[i] = 1; end
      K_EI: m_ie[i] = 1;
      K_DI: m_ie[i] = 0;
      default: ;
    endcase
    if (flt) m_fault[i] = 1;
    if (m_fault[i] && i == 0) m_halt[i] = 1;
  endtask

  // ---------------- driver tasks ----------------
  // Random opcode with a fixed class prefix; fn < 0 keeps random low bits
  function automatic logic [OPW-1:0] mk_op(input int prefix, input int plen, input int fn);
    logic [OPW-1:0] r;
    logic [2:0]     f;
    r = OPW'($urandom);
    for (int b = 0; b < plen; b++) r[OPW-1-b] = prefix[plen-1-b];
    if (fn >= 0) begin
      f      = 3'(fn);
      r[2:0] = f;
    end
    return r;
  endfunction

  function automatic logic [OPW-1:0] rand_op();
    int r;
    r = $urandom_range(0, 15);
    if (r <= 2)  return mk_op(1, 1, -1);
    if (r <= 4)  return mk_op(1, 2, -1);
    if (r <= 6)  return mk_op(1, 3, $urandom_range(0, 5));
    if (r <= 8)  return mk_op(1, 3, 6);
    if (r <= 10) return mk_op(1, 3, 7);
    if (r == 11) return mk_op(1, 4, -1);
    if (r == 12) return mk_op(0, 4, 1);
    if (r == 13) return mk_op(0, 4, 2);
    if (r == 14) return mk_op(0, 4, 3);
    r = $urandom_range(0, 4);
    return mk_op(0, 4, (r == 0) ? 0 : r + 3);
  endfunction

  task automatic do_cycle(input logic [OPW-1:0] op, input bit za, input bit ca,
                          input bit irq_v, input bit rst);
    logic [8:0] got;
    @(negedge clk);
    reset = rst; opcode = op; z_alu = za; c_alu = ca; irq = irq_v;
    #1;
    for (int i = 0; i < 2; i++) begin
      if (state_known) begin
        check($sformatf("z_flag%0d", i), z_flag[i], m_z[i]);
        check($sformatf("c_flag%0d", i), c_flag[i], m_c[i]);
        check($sformatf("ie%0d", i), ie[i], m_ie[i]);
        check($sformatf("sp_count%0d", i), sp_count[i], 32'(m_sp[i]));
        check($sformatf("fault%0d", i), fault[i], m_fault[i]);
        check($sformatf("halted%0d", i), halted[i], m_halt[i]);
      end
      exp_q.push_back(model_ctl(i, op, rst));
    end
    for (int i = 0; i < 2; i++) begin
      got = {s_inc[i], s_inm[i], s_irq[i], we3[i], push[i], pop[i], op_alu[i]};
      check($sformatf("ctl%0d op=%0h", i, op), got, exp_q.pop_front());
    end
    for (int i = 0; i < 2; i++) model_step(i, op, za, ca, irq_v, rst);
    if (rst) state_known = 1'b1;
  endtask

  task automatic nop(input bit irq_v);
    do_cycle(mk_op(0, 4, 0), 0, 0, irq_v, 0);
  endtask

  task automatic do_reset();
    do_cycle(rand_op(), 1, 1, 0, 1);
    do_cycle(rand_op(), 1, 1, 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit irq_r;
    do_reset();

    // Flag write then dependent branch
    do_cycle(mk_op(1, 2, -1), 1, 0, 0, 0);
    do_cycle(mk_op(1, 3, 1), 0, 1, 0, 0);
    do_cycle(mk_op(1, 2, -1), 1, 0, 0, 0);
    do_cycle(mk_op(1, 3, 2), 0, 0, 0, 0);

    // Interrupt: EI alongside irq rise, DI suppressed by entry, RETI restores flags
    do_cycle(mk_op(1, 4, -1), 1, 1, 0, 0);
    do_cycle(mk_op(0, 4, 1), 0, 0, 1, 0);
    do_cycle(mk_op(0, 4, 2), 0, 0, 0, 0);
    do_cycle(mk_op(1, 4, -1), 0, 0, 0, 0);
    do_cycle(mk_op(0, 4, 3), 0, 0, 0, 0);
    @(posedge clk); #1;
    check("reti_z", z_flag[0], 1);
    check("reti_c", c_flag[0], 1);
    check("reti_ie", ie[0], 1);
    check("reti_sp", sp_count[0], 0);
    do_cycle(mk_op(0, 4, 2), 0, 0, 0, 0);

    // Fill the stack, then overflow
    do_reset();
    for (int n = 0; n < DEPTH; n++) do_cycle(mk_op(1, 3, 6), 0, 0, 0, 0);
    @(posedge clk); #1;
    check("sp_full0", sp_count[0], DEPTH);
    check("sp_full1", sp_count[1], DEPTH);
    do_cycle(mk_op(1, 3, 6), 0, 0, 0, 0);
    @(posedge clk); #1;
    check("ovf_fault0", fault[0], 1);
    check("ovf_halt0", halted[0], 1);
    check("ovf_fault1", fault[1], 1);
    check("ovf_halt1", halted[1], 0);
    nop(1);
    nop(0);

    // Underflow on an empty stack
    do_reset();
    do_cycle(mk_op(1, 3, 7), 0, 0, 0, 0);
    do_cycle(mk_op(1, 1, -1), 1, 0, 0, 0);
    do_cycle(mk_op(0, 4, 3), 0, 0, 0, 0);
    nop(0);

    // Pending irq with a full stack waits, then enters after one RET
    do_reset();
    do_cycle(mk_op(0, 4, 1), 0, 0, 0, 0);
    for (int n = 0; n < DEPTH; n++) do_cycle(mk_op(1, 3, 6), 0, 0, 0, 0);
    for (int n = 0; n < 3; n++) nop(1);
    @(posedge clk); #1;
    check("full_nofault", fault[0], 0);
    do_cycle(mk_op(1, 3, 7), 0, 0, 1, 0);
    nop(1);
    @(posedge clk); #1;
    check("late_entry_ie", ie[0], 0);
    nop(0);
    nop(0);

    // Random traffic with occasional resets
    do_reset();
    irq_r = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) irq_r = !irq_r;
      do_cycle(rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), irq_r,
               $urandom_range(0, 99) == 0);
    end
    nop(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
